split_rr_arbiter: RTL and testbench

- Next-generation bus arbiter for the serial-bus interconnect, generalised to NUM_MASTERS masters and NUM_SLAVES slaves.
- Selectable fixed-priority or round-robin arbitration.
- Split-transaction parking: a split slave releases the bus, and the parked master regains it with top priority when the slave finishes.
- Watchdog timeout reclaims the bus from a hung owner. Sits between the master modules and the interconnect mux, replacing the two-master request/grant logic.

---
 rtl/split_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_split_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_rr_arbiter.sv
// split_rr_arbiter
//   Bus arbiter for NUM_MASTERS masters and NUM_SLAVES slaves. It offers
//   fixed-priority or round-robin selection, split-transaction parking with
//   top-priority resume, and a watchdog that reclaims the bus from a hung owner.
//   Flow: IDLE -> ARB (one cycle) -> BUSY -> IDLE. Every output is registered.
// Ports:
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   mode              0 = fixed priority, 1 = round-robin (sampled in IDLE)
//   request           per-master level request
//   slave_select      master i target at [i*SLAVE_LEN +: SLAVE_LEN]
//   trans_done        owner's transaction-complete pulse
//   split_en          per-slave split request/hold
//   grant             one-hot grant, held through BUSY
//   granted_slave     target of the current owner
//   arbiter_busy      high in ARB
//   bus_busy          high in BUSY
//   split_pending     master parked on a split slave
//   timeout_err       one-cycle pulse on watchdog release
module split_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 3,
    parameter int SLAVE_LEN   = 2,
    parameter int TIMEOUT     = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             mode,
    input  logic [NUM_MASTERS-1:0]           request,
    input  logic [NUM_MASTERS*SLAVE_LEN-1:0] slave_select,
    input  logic                             trans_done,
    input  logic [NUM_SLAVES-1:0]            split_en,
    output logic [NUM_MASTERS-1:0]           grant,
    output logic [SLAVE_LEN-1:0]             granted_slave,
    output logic                             arbiter_busy,
    output logic                             bus_busy,
    output logic [NUM_MASTERS-1:0]           split_pending,
    output logic                             timeout_err
);

    localparam int PTR_W = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ARB, BUSY} state_t;

    state_t                                  state;
    logic                                    mode_q;
    logic [PTR_W-1:0]                        rr_ptr;
    logic [PTR_W-1:0]                        owner;
    logic [TIMEOUT_W-1:0]                    wd;
    logic [NUM_MASTERS-1:0][SLAVE_LEN-1:0]   parked_slave;
    logic [NUM_MASTERS-1:0]                  resume;

    logic [NUM_MASTERS-1:0][SLAVE_LEN-1:0]   tgt;
    logic [NUM_MASTERS-1:0]                  blocked;
    logic [NUM_MASTERS-1:0]                  elig;
    logic [(1<<SLAVE_LEN)-1:0]               split_pad;
    logic                                    win_found;
    logic [PTR_W-1:0]                        win;
    logic [PTR_W-1:0]                        owner_next;
    logic                                    rel_done, rel_split, rel_to;

    // split_en widened to the full select range so any select value indexes safely
    always_comb begin
        split_pad = '0;
        split_pad[NUM_SLAVES-1:0] = split_en;
    end

    // Eligibility: requesting, not parked, in-range target, target not parked by someone else
    always_comb begin
        tgt     = '0;
        blocked = '0;
        elig    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            tgt[i] = slave_select[i*SLAVE_LEN +: SLAVE_LEN];
            for (int j = 0; j < NUM_MASTERS; j++)
                if (j != i && split_pending[j] && parked_slave[j] == tgt[i])
                    blocked[i] = 1'b1;
            elig[i] = request[i] && !split_pending[i] && !blocked[i] &&
                      ({1'b0, tgt[i]} < (SLAVE_LEN+1)'(NUM_SLAVES));
        end
    end

    // Winner: resumed masters first, then fixed or round-robin order.
    // Descending loops let the lowest index / nearest-to-pointer candidate win.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win       = '0;
        for (int i = NUM_MASTERS-1; i >= 0; i--)
            if (elig[i] && resume[i]) begin
                win_found = 1'b1;
                win       = PTR_W'(i);
            end
        if (!win_found) begin
            if (!mode_q) begin
                for (int i = NUM_MASTERS-1; i >= 0; i--)
                    if (elig[i]) begin
                        win_found = 1'b1;
                        win       = PTR_W'(i);
                    end
            end else begin
                for (int k = NUM_MASTERS-1; k >= 0; k--) begin
                    idx = (int'(rr_ptr) + k) % NUM_MASTERS;
                    if (elig[idx]) begin
                        win_found = 1'b1;
                        win       = PTR_W'(idx);
                    end
                end
            end
        end
    end

    assign owner_next = (owner == PTR_W'(NUM_MASTERS-1)) ? '0 : owner + PTR_W'(1);

    // BUSY exit causes, ordered: normal release beats park beats watchdog
    assign rel_done  = trans_done || !request[owner];
    assign rel_split = !rel_done && split_pad[granted_slave];
    assign rel_to    = !rel_done && !rel_split && (wd == TIMEOUT_W'(TIMEOUT-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            mode_q        <= 1'b0;
            rr_ptr        <= '0;
            owner         <= '0;
            wd            <= '0;
            parked_slave  <= '0;
            resume        <= '0;
            grant         <= '0;
            granted_slave <= '0;
            arbiter_busy  <= 1'b0;
            bus_busy      <= 1'b0;
            split_pending <= '0;
            timeout_err   <= 1'b0;
        end else begin
            timeout_err <= 1'b0;

            // Unpark runs in every state; several masters may resume together
            for (int i = 0; i < NUM_MASTERS; i++)
                if (split_pending[i] && !split_pad[parked_slave[i]]) begin
                    split_pending[i] <= 1'b0;
                    resume[i]        <= 1'b1;
                end

            case (state)
                IDLE: begin
                    if (|elig) begin
                        state        <= ARB;
                        arbiter_busy <= 1'b1;
                        mode_q       <= mode;
                    end
                end
                ARB: begin
                    arbiter_busy <= 1'b0;
                    if (win_found) begin
                        state         <= BUSY;
                        grant         <= NUM_MASTERS'(1) << win;
                        granted_slave <= tgt[win];
                        owner         <= win;
                        bus_busy      <= 1'b1;
                        wd            <= '0;
                        resume[win]   <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    wd <= wd + TIMEOUT_W'(1);
                    if (rel_split) begin
                        split_pending[owner] <= 1'b1;
                        parked_slave[owner]  <= granted_slave;
                    end
                    if (rel_to)
                        timeout_err <= 1'b1;
                    if (rel_done || rel_split || rel_to) begin
                        state         <= IDLE;
                        grant         <= '0;
                        granted_slave <= '0;
                        bus_busy      <= 1'b0;
                        wd            <= '0;
                        if (mode_q)
                            rr_ptr <= owner_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split_rr_arbiter.sv
module tb_split_rr_arbiter;

    localparam int NM = 4;
    localparam int NS = 3;
    localparam int SL = 2;
    localparam int TO = 16;
    localparam int TW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic [NM-1:0]     request;
    logic [NM*SL-1:0]  slave_select;
    logic              trans_done;
    logic [NS-1:0]     split_en;
    logic [NM-1:0]     grant;
    logic [SL-1:0]     granted_slave;
    logic              arbiter_busy;
    logic              bus_busy;
    logic [NM-1:0]     split_pending;
    logic              timeout_err;

    always #5 clk = ~clk;

    split_rr_arbiter #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_LEN(SL), .TIMEOUT(TO), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .request(request),
        .slave_select(slave_select), .trans_done(trans_done), .split_en(split_en),
        .grant(grant), .granted_slave(granted_slave), .arbiter_busy(arbiter_busy),
        .bus_busy(bus_busy), .split_pending(split_pending), .timeout_err(timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NM-1:0] grant;
        logic [SL-1:0] slave;
    } gexp_t;

    gexp_t sb_q[$];
    gexp_t sb_e;
    logic  bb_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every new grant must match the next expected owner
    always @(negedge clk) begin
        if (reset) begin
            bb_prev <= 1'b0;
        end else begin
            if (bus_busy && !bb_prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got grant %b slave %0d, expected none at %0t",
                             grant, granted_slave, $time);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_grant", 32'(grant), 32'(sb_e.grant));
                    chk("sb_slave", 32'(granted_slave), 32'(sb_e.slave));
                end
            end
            bb_prev <= bus_busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; request = '0; trans_done = 1'b0; split_en = '0; mode = 1'b0;
        slave_select = '0;
        #1;
        chk("reset_outputs", 32'({grant, granted_slave, arbiter_busy, bus_busy,
                                  split_pending, timeout_err}), 32'd0);
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_grant(input string name, input int budget);
        int n;
        n = 0;
        while (!bus_busy && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(bus_busy), 32'd1);
    endtask

    task automatic set_ss(input logic [SL-1:0] s0, input logic [SL-1:0] s1,
                          input logic [SL-1:0] s2, input logic [SL-1:0] s3);
        slave_select = {s3, s2, s1, s0};
    endtask

    task automatic push(input logic [NM-1:0] g, input logic [SL-1:0] s);
        gexp_t e;
        e.grant = g;
        e.slave = s;
        sb_q.push_back(e);
    endtask

    task automatic finish_txn(input logic [NM-1:0] req_after);
        trans_done = 1'b1;
        request    = req_after;
        tick();
        trans_done = 1'b0;
    endtask

    typedef struct {
        logic [NM-1:0] req;
        logic          td;
        logic [NM-1:0] g;
        logic [SL-1:0] gs;
        logic          ab;
        logic          bb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // cycle-accurate fixed-priority walk: row k = inputs in cycle k, outputs seen in cycle k
        tbl[0]  = '{4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{4'b1010, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1};
        tbl[3]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1};
        tbl[4]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b1};
        tbl[5]  = '{4'b1000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1};
        tbl[6]  = '{4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        tbl[7]  = '{4'b1000, 1'b0, 4'b0000, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{4'b1000, 1'b0, 4'b1000, 2'd2, 1'b0, 1'b1};
        tbl[9]  = '{4'b0000, 1'b1, 4'b1000, 2'd2, 1'b0, 1'b1};
        tbl[10] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        // fixed priority
        do_reset();
        set_ss(2'd0, 2'd1, 2'd0, 2'd2);
        push(4'b0010, 2'd1);
        push(4'b1000, 2'd2);
        for (int k = 0; k < 11; k++) begin
            request    = tbl[k].req;
            trans_done = tbl[k].td;
            #1;
            chk("fp_grant", 32'(grant), 32'(tbl[k].g));
            chk("fp_slave", 32'(granted_slave), 32'(tbl[k].gs));
            chk("fp_arb_busy", 32'(arbiter_busy), 32'(tbl[k].ab));
            chk("fp_bus_busy", 32'(bus_busy), 32'(tbl[k].bb));
            tick();
        end

        // round-robin fairness
        do_reset();
        mode = 1'b1;
        push(4'b0001, 2'd0);
        push(4'b0010, 2'd0);
        push(4'b0100, 2'd0);
        push(4'b1000, 2'd0);
        push(4'b0001, 2'd0);
        request = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("rr_grant_seen", 8);
            tick();
            tick();
            finish_txn((k == 4) ? 4'b0000 : 4'b1111);
        end
        repeat (4) tick();

        // split parking, contention on the parked slave, top-priority resume
        do_reset();
        mode = 1'b1;
        set_ss(2'd2, 2'd0, 2'd2, 2'd1);
        push(4'b0001, 2'd2);
        request = 4'b0001;
        wait_grant("split_m0_grant", 8);
        split_en = 3'b100;
        request  = 4'b0111;
        push(4'b0010, 2'd0);
        tick();
        chk("split_pending_set", 32'(split_pending), 32'h1);
        chk("split_released", 32'({grant, bus_busy}), 32'd0);
        wait_grant("split_m1_grant", 8);
        repeat (3) tick();
        finish_txn(4'b0101);
        repeat (12) tick();
        chk("contention_idle", 32'({arbiter_busy, bus_busy}), 32'd0);
        chk("still_parked", 32'(split_pending), 32'h1);
        split_en = 3'b000;
        request  = 4'b1101;
        push(4'b0001, 2'd2);
        push(4'b0100, 2'd2);
        push(4'b1000, 2'd1);
        tick();
        chk("unparked", 32'(split_pending), 32'd0);
        wait_grant("resume_m0_grant", 8);
        tick();
        finish_txn(4'b1100);
        wait_grant("after_resume_m2", 8);
        tick();
        finish_txn(4'b1000);
        wait_grant("after_resume_m3", 8);
        tick();
        finish_txn(4'b0000);
        repeat (3) tick();

        // watchdog timeout
        do_reset();
        set_ss(2'd0, 2'd1, 2'd0, 2'd0);
        push(4'b0001, 2'd0);
        push(4'b0010, 2'd1);
        request = 4'b0011;
        wait_grant("to_m0_grant", 8);
        for (int k = 1; k <= TO; k++) begin
            chk("to_still_busy", 32'(bus_busy), 32'd1);
            chk("to_no_err_yet", 32'(timeout_err), 32'd0);
            if (k < TO) tick();
        end
        tick();
        chk("to_err_pulse", 32'(timeout_err), 32'd1);
        chk("to_grant_dropped", 32'(grant), 32'd0);
        request = 4'b0010;
        tick();
        chk("to_err_one_cycle", 32'(timeout_err), 32'd0);
        wait_grant("to_next_grant", 8);
        finish_txn(4'b0000);
        repeat (3) tick();

        // trans_done and split_en together: no park
        do_reset();
        set_ss(2'd2, 2'd0, 2'd0, 2'd0);
        push(4'b0001, 2'd2);
        request = 4'b0001;
        wait_grant("tdsplit_grant", 8);
        tick();
        trans_done = 1'b1;
        split_en   = 3'b100;
        tick();
        trans_done = 1'b0;
        request    = 4'b0000;
        chk("td_beats_split", 32'(split_pending), 32'd0);
        chk("td_released", 32'(bus_busy), 32'd0);
        split_en = 3'b000;
        repeat (3) tick();

        // out-of-range target never granted
        do_reset();
        set_ss(2'd3, 2'd1, 2'd0, 2'd0);
        request = 4'b0001;
        repeat (10) tick();
        chk("oor_ignored", 32'({arbiter_busy, bus_busy, grant}), 32'd0);
        push(4'b0010, 2'd1);
        request = 4'b0011;
        wait_grant("oor_other_grant", 8);
        tick();
        finish_txn(4'b0001);
        repeat (6) tick();
        chk("oor_still_ignored", 32'({arbiter_busy, bus_busy, grant}), 32'd0);
        request = 4'b0000;

        // asynchronous reset in the middle of BUSY with a parked master
        do_reset();
        set_ss(2'd2, 2'd0, 2'd0, 2'd0);
        push(4'b0001, 2'd2);
        request = 4'b0001;
        wait_grant("rst_m0_grant", 8);
        split_en = 3'b100;
        request  = 4'b0011;
        push(4'b0010, 2'd0);
        tick();
        chk("rst_parked", 32'(split_pending), 32'h1);
        wait_grant("rst_m1_grant", 8);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_clear", 32'({grant, granted_slave, arbiter_busy, bus_busy,
                                      split_pending, timeout_err}), 32'd0);
        request  = 4'b0000;
        split_en = 3'b000;
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("after_reset_idle", 32'({bus_busy, split_pending}), 32'd0);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
